// File: rtl/uart_debug_bridge_pkg.sv
// Shared constants and command FSM encoding for the UART-to-Wishbone debug bridge.
package uart_debug_bridge_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspAck   = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h45;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte strobe and framing flag.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RxIdle  = 2'd0;
  localparam logic [1:0] RxStart = 2'd1;
  localparam logic [1:0] RxData  = 2'd2;
  localparam logic [1:0] RxStop  = 2'd3;

  logic            sync1_q, sync2_q;
  logic [1:0]      state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic            valid_q, frame_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RxIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        RxIdle: begin
          if (!sync2_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            // A start bit that is high again at its mid-point was a glitch.
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            sh_q  <= {sync2_q, sh_q[7:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q       <= '0;
            state_q     <= RxIdle;
            valid_q     <= sync2_q;
            frame_err_q <= !sync2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign data_o      = sh_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_debug_bridge.sv
// UART debug bridge: 'W'/'R' commands over 8N1 drive single Wishbone cycles, status sent back.
module uart_debug_bridge
  import uart_debug_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (rx_data),
    .valid_o    (rx_valid),
    .frame_err_o(rx_frame_err)
  );

  state_e          state_q;
  logic [1:0]      byte_cnt_q;
  logic            we_q, cyc_q;
  logic [31:0]     adr_q, dat_q;
  logic [TmoW-1:0] tmo_q;
  logic [39:0]     resp_q;
  logic [2:0]      resp_left_q;
  logic [8:0]      tx_sh_q;
  logic [3:0]      tx_bits_q;
  logic [CntW-1:0] tx_clk_q;
  logic            tx_busy_q, tx_q;

  logic tx_bit_end, tx_ready, tx_load;

  // The next byte may load on the final stop-bit clock so bytes go out back-to-back.
  always_comb begin
    tx_bit_end = tx_busy_q && (tx_clk_q == BitLast);
    tx_ready   = !tx_busy_q || (tx_bit_end && (tx_bits_q == 4'd9));
    tx_load    = (state_q == StResp) && tx_ready && (resp_left_q != 3'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid && (rx_data == CmdWrite || rx_data == CmdRead)) begin
            we_q       <= (rx_data == CmdWrite);
            byte_cnt_q <= '0;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          if (rx_frame_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            adr_q      <= {adr_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              if (we_q) begin
                state_q <= StData;
              end else begin
                state_q <= StBus;
                cyc_q   <= 1'b1;
                tmo_q   <= '0;
              end
            end
          end
        end
        StData: begin
          if (rx_frame_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            dat_q      <= {dat_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= StBus;
              cyc_q   <= 1'b1;
              tmo_q   <= '0;
            end
          end
        end
        StBus: begin
          tmo_q <= tmo_q + 1'b1;
          if (err_i || rty_i || (!ack_i && tmo_q == TmoLast)) begin
            cyc_q       <= 1'b0;
            resp_q      <= {RspErr, 32'h0};
            resp_left_q <= 3'd1;
            state_q     <= StResp;
          end else if (ack_i) begin
            cyc_q       <= 1'b0;
            resp_q      <= {RspAck, dat_i};
            resp_left_q <= we_q ? 3'd1 : 3'd5;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (tx_load) begin
            resp_q      <= {resp_q[31:0], 8'h00};
            resp_left_q <= resp_left_q - 1'b1;
          end else if (resp_left_q == 3'd0 && !tx_busy_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_bits_q <= '0;
      tx_clk_q  <= '0;
    end else if (tx_load) begin
      tx_q      <= 1'b0;
      tx_busy_q <= 1'b1;
      tx_sh_q   <= {1'b1, resp_q[39:32]};
      tx_bits_q <= '0;
      tx_clk_q  <= '0;
    end else if (tx_busy_q) begin
      if (tx_bit_end) begin
        tx_clk_q <= '0;
        if (tx_bits_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_q      <= tx_sh_q[0];
          tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
          tx_bits_q <= tx_bits_q + 1'b1;
        end
      end else begin
        tx_clk_q <= tx_clk_q + 1'b1;
      end
    end
  end

  assign tx_o  = tx_q;
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o  = we_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign sel_o = 4'b1111;

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Directed bench for uart_debug_bridge: UART commands in, Wishbone responder and UART decode out.
module tb_uart_debug_bridge;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Tmo = 16;

  logic        clk_i = 1'b0;
  logic        rst_i, rx_i, tx_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  uart_debug_bridge #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT     (Tmo)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_i (rx_i),
    .tx_o (tx_o),
    .cyc_o(cyc_o),
    .stb_o(stb_o),
    .we_o (we_o),
    .adr_o(adr_o),
    .dat_o(dat_o),
    .sel_o(sel_o),
    .dat_i(dat_i),
    .ack_i(ack_i),
    .err_i(err_i),
    .rty_i(rty_i)
  );

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(Cpb);
    end
    rx_i = stop;
    tick(Cpb);
    rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 3000 && cyc_o !== 1'b1; i++) tick(1);
    check_bit(tag, cyc_o, 1'b1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic       found;
    b = 8'h00;
    for (int i = 0; i < 400 && tx_o !== 1'b0; i++) tick(1);
    found = (tx_o === 1'b0);
    check_bit({tag, "_start"}, found, 1'b1);
    if (found) begin
      tick(Cpb / 2);
      for (int k = 0; k < 8; k++) begin
        tick(Cpb);
        b[k] = tx_o;
      end
      check_word(tag, {24'h0, b}, {24'h0, exp});
      tick(Cpb);
      check_bit({tag, "_stop"}, tx_o, 1'b1);
    end
  endtask

  task automatic tx_quiet(input string tag, input int n);
    logic low;
    low = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tx_o !== 1'b1) low = 1'b1;
      tick(1);
    end
    check_bit(tag, low, 1'b0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    rx_i  = 1'b1;
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = 32'h0;
    tick(3);
    rst_i = 1'b0;
    tick(1);

    check_bit("rst_cyc", cyc_o, 1'b0);
    check_bit("rst_stb", stb_o, 1'b0);
    check_bit("rst_we", we_o, 1'b0);
    check_word("rst_adr", adr_o, 32'h0);
    check_word("rst_dat", dat_o, 32'h0);
    check_word("rst_sel", {28'h0, sel_o}, 32'hF);
    check_bit("rst_tx", tx_o, 1'b1);

    // Unknown command byte is ignored.
    send_byte(8'h41, 1'b1);
    tx_quiet("ignored_tx", 60);
    check_bit("ignored_cyc", cyc_o, 1'b0);

    // Write 0x00000003 to 0x40000000, ack on the second edge.
    send_byte(8'h57, 1'b1);
    send_word(32'h4000_0000);
    send_word(32'h0000_0003);
    wait_cyc("wr_cyc");
    check_word("wr_adr", adr_o, 32'h4000_0000);
    check_word("wr_dat", dat_o, 32'h0000_0003);
    check_bit("wr_we", we_o, 1'b1);
    check_bit("wr_stb", stb_o, 1'b1);
    check_word("wr_sel", {28'h0, sel_o}, 32'hF);
    tick(1);
    check_word("wr_adr_hold", adr_o, 32'h4000_0000);
    check_bit("wr_cyc_hold", cyc_o, 1'b1);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    check_bit("wr_cyc_end", cyc_o, 1'b0);
    check_bit("wr_stb_end", stb_o, 1'b0);
    expect_tx("wr_rsp", 8'h4B);
    tx_quiet("wr_quiet", 60);

    // Read 0x10000004, data DEADBEEF.
    send_byte(8'h52, 1'b1);
    send_word(32'h1000_0004);
    wait_cyc("rd_cyc");
    check_word("rd_adr", adr_o, 32'h1000_0004);
    check_bit("rd_we", we_o, 1'b0);
    dat_i = 32'hDEAD_BEEF;
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    dat_i = 32'h0;
    check_bit("rd_cyc_end", cyc_o, 1'b0);
    expect_tx("rd_rsp0", 8'h4B);
    expect_tx("rd_rsp1", 8'hDE);
    expect_tx("rd_rsp2", 8'hAD);
    expect_tx("rd_rsp3", 8'hBE);
    expect_tx("rd_rsp4", 8'hEF);
    tx_quiet("rd_quiet", 60);

    // Read with no responder: cyc_o must be high for exactly Tmo cycles.
    send_byte(8'h52, 1'b1);
    send_word(32'h2000_0000);
    wait_cyc("tmo_cyc");
    n = 0;
    for (int i = 0; i < 100 && cyc_o === 1'b1; i++) begin
      n++;
      tick(1);
    end
    check_word("tmo_len", 32'(n), 32'(Tmo));
    expect_tx("tmo_rsp", 8'h45);
    tx_quiet("tmo_quiet", 60);

    // err_i and ack_i together: error wins, no data bytes follow.
    send_byte(8'h52, 1'b1);
    send_word(32'h3000_0000);
    wait_cyc("err_cyc");
    dat_i = 32'hCAFE_F00D;
    err_i = 1'b1;
    ack_i = 1'b1;
    tick(1);
    err_i = 1'b0;
    ack_i = 1'b0;
    dat_i = 32'h0;
    check_bit("err_cyc_end", cyc_o, 1'b0);
    expect_tx("err_rsp", 8'h45);
    tx_quiet("err_quiet", 60);

    // Framing error on 'W' is discarded; the following read runs alone.
    send_byte(8'h57, 1'b0);
    tick(20);
    send_byte(8'h52, 1'b1);
    send_word(32'h1000_0000);
    wait_cyc("fe_cyc");
    check_word("fe_adr", adr_o, 32'h1000_0000);
    check_bit("fe_we", we_o, 1'b0);
    dat_i = 32'h1234_5678;
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    dat_i = 32'h0;
    expect_tx("fe_rsp0", 8'h4B);
    expect_tx("fe_rsp1", 8'h12);
    expect_tx("fe_rsp2", 8'h34);
    expect_tx("fe_rsp3", 8'h56);
    expect_tx("fe_rsp4", 8'h78);
    tx_quiet("fe_quiet", 60);

    // Reset during a bus cycle abandons it silently.
    send_byte(8'h52, 1'b1);
    send_word(32'h4000_0000);
    wait_cyc("mr_cyc");
    rst_i = 1'b1;
    tick(1);
    check_bit("mr_cyc", cyc_o, 1'b0);
    check_bit("mr_stb", stb_o, 1'b0);
    check_bit("mr_tx", tx_o, 1'b1);
    check_word("mr_adr", adr_o, 32'h0);
    rst_i = 1'b0;
    tx_quiet("mr_quiet", 60);

    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0010);
    send_word(32'h0000_0055);
    wait_cyc("pr_cyc");
    check_word("pr_adr", adr_o, 32'h0000_0010);
    check_word("pr_dat", dat_o, 32'h0000_0055);
    check_bit("pr_we", we_o, 1'b1);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    expect_tx("pr_rsp", 8'h4B);
    tx_quiet("pr_quiet", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
